// File: rtl/rice_core_register_file_mp.sv
// Multi-ported integer register file with write-to-read bypass, a busy scoreboard
// and a post-reset clear sequencer that zeroes x1..x31 before the file reports ready.
module rice_core_register_file_mp #(
  parameter int XLEN   = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int BYPASS = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic                     o_ready,
  input  logic [NUM_RD*5-1:0]      i_rs_addr,
  output logic [NUM_RD*XLEN-1:0]   o_rs_value,
  output logic [NUM_RD-1:0]        o_rs_busy,
  input  logic [NUM_WR-1:0]        i_wr_valid,
  input  logic [NUM_WR*5-1:0]      i_wr_rd,
  input  logic [NUM_WR*XLEN-1:0]   i_wr_value,
  input  logic                     i_alloc_valid,
  input  logic [4:0]               i_alloc_rd
);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e          state_q, state_d;
  logic [4:0]      clear_idx_q, clear_idx_d;
  logic            ready_q, ready_d;
  logic [31:0]     busy_q, busy_d;
  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];
  logic            run;

  assign run     = (state_q == RUN);
  assign o_ready = ready_q;

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    regs_d      = regs_q;
    if (!run) begin
      regs_d[clear_idx_q] = '0;
      clear_idx_d         = clear_idx_q + 5'd1;
      if (clear_idx_q == 5'd31) begin
        state_d = RUN;
        ready_d = 1'b1;
      end
    end else begin
      // Ascending port order makes the highest-indexed writer win.
      for (int w = 0; w < NUM_WR; w++) begin
        if (i_wr_valid[w] && (i_wr_rd[5*w +: 5] != 5'd0)) begin
          regs_d[i_wr_rd[5*w +: 5]] = i_wr_value[XLEN*w +: XLEN];
          busy_d[i_wr_rd[5*w +: 5]] = 1'b0;
        end
      end
      // A new producer allocated in the same cycle as a completing write keeps busy set.
      if (i_alloc_valid && (i_alloc_rd != 5'd0)) busy_d[i_alloc_rd] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= CLEAR;
      clear_idx_q <= 5'd1;
      ready_q     <= 1'b0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  // Storage is never reset; the sequencer zeroes it after every reset.
  always_ff @(posedge i_clk) begin
    regs_q <= regs_d;
  end

  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_val;
  logic            rd_busy;
  logic            wr_hit;
  logic            alloc_hit;

  always_comb begin
    o_rs_value = '0;
    o_rs_busy  = '0;
    rd_addr    = '0;
    rd_val     = '0;
    rd_busy    = 1'b0;
    wr_hit     = 1'b0;
    alloc_hit  = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_addr   = i_rs_addr[5*p +: 5];
      rd_val    = regs_q[rd_addr];
      rd_busy   = busy_q[rd_addr];
      wr_hit    = 1'b0;
      alloc_hit = i_alloc_valid && (i_alloc_rd == rd_addr);
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (i_wr_valid[w] && (i_wr_rd[5*w +: 5] == rd_addr)) begin
            rd_val = i_wr_value[XLEN*w +: XLEN];
            wr_hit = 1'b1;
          end
        end
      end
      if (wr_hit && !alloc_hit) rd_busy = 1'b0;
      if (!run || (rd_addr == 5'd0)) begin
        rd_val  = '0;
        rd_busy = 1'b0;
      end
      o_rs_value[XLEN*p +: XLEN] = rd_val;
      o_rs_busy[p]               = rd_busy;
    end
  end

endmodule

// File: tb/tb_rice_core_register_file_mp.sv
// Bench for rice_core_register_file_mp: two instances (bypass on/off) sharing stimulus,
// checked against a cycle-count based reference model plus a directed vector table.
module tb_rice_core_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rs_addr;
  logic [1:0]  wr_valid;
  logic [9:0]  wr_rd;
  logic [63:0] wr_value;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;

  logic        ready_b, ready_n;
  logic [63:0] val_b, val_n;
  logic [1:0]  busy_b, busy_n;

  always #5 clk = ~clk;

  rice_core_register_file_mp #(.XLEN(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut (
    .i_clk(clk), .i_rst(rst), .o_ready(ready_b),
    .i_rs_addr(rs_addr), .o_rs_value(val_b), .o_rs_busy(busy_b),
    .i_wr_valid(wr_valid), .i_wr_rd(wr_rd), .i_wr_value(wr_value),
    .i_alloc_valid(alloc_valid), .i_alloc_rd(alloc_rd)
  );

  rice_core_register_file_mp #(.XLEN(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_nb (
    .i_clk(clk), .i_rst(rst), .o_ready(ready_n),
    .i_rs_addr(rs_addr), .o_rs_value(val_n), .o_rs_busy(busy_n),
    .i_wr_valid(wr_valid), .i_wr_rd(wr_rd), .i_wr_value(wr_value),
    .i_alloc_valid(alloc_valid), .i_alloc_rd(alloc_rd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents, busy flags and cycles elapsed since reset release.
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  int          m_cnt;
  bit          m_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit          run;
    logic [4:0]  a;
    logic [31:0] eb, en;
    bit          hit, ahit, bb, bn;
    if (!m_known) return;
    run = (m_cnt >= 31);
    chk("ready_byp", {31'd0, ready_b}, {31'd0, run});
    chk("ready_nobyp", {31'd0, ready_n}, {31'd0, run});
    for (int p = 0; p < 2; p++) begin
      a    = rs_addr[5*p +: 5];
      eb   = m_mem[a];
      en   = m_mem[a];
      hit  = 1'b0;
      ahit = alloc_valid && (alloc_rd == a);
      for (int w = 0; w < 2; w++)
        if (wr_valid[w] && wr_rd[5*w +: 5] == a) begin
          eb  = wr_value[32*w +: 32];
          hit = 1'b1;
        end
      bb = m_busy[a] && !(hit && !ahit);
      bn = m_busy[a];
      if (!run || a == 5'd0) begin
        eb = 0; en = 0; bb = 0; bn = 0;
      end
      chk($sformatf("val_byp[%0d] x%0d", p, a), val_b[32*p +: 32], eb);
      chk($sformatf("val_nobyp[%0d] x%0d", p, a), val_n[32*p +: 32], en);
      chk($sformatf("busy_byp[%0d] x%0d", p, a), {31'd0, busy_b[p]}, {31'd0, bb});
      chk($sformatf("busy_nobyp[%0d] x%0d", p, a), {31'd0, busy_n[p]}, {31'd0, bn});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_known = 1'b1;
      m_cnt   = 0;
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 0;
        m_busy[i] = 0;
      end
    end else if (m_known && m_cnt < 31) begin
      m_cnt++;
    end else if (m_known) begin
      for (int w = 0; w < 2; w++)
        if (wr_valid[w] && wr_rd[5*w +: 5] != 5'd0) begin
          m_mem[wr_rd[5*w +: 5]]  = wr_value[32*w +: 32];
          m_busy[wr_rd[5*w +: 5]] = 0;
        end
      if (alloc_valid && alloc_rd != 5'd0) m_busy[alloc_rd] = 1;
    end
    #1;
  endtask

  task automatic step();
    #3;
    model_check();
    tick();
  endtask

  task automatic idle();
    rs_addr = '0; wr_valid = '0; wr_rd = '0; wr_value = '0;
    alloc_valid = 1'b0; alloc_rd = '0;
  endtask

  task automatic rand_inputs();
    rs_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    wr_valid    = 2'($urandom);
    wr_rd       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    wr_value    = {$urandom, $urandom};
    alloc_valid = 1'($urandom);
    alloc_rd    = 5'($urandom_range(0, 7));
  endtask

  typedef struct {
    logic [1:0]  wv;
    logic [4:0]  rd0, rd1;
    logic [31:0] v0, v1;
    logic        av;
    logic [4:0]  ard;
    logic [4:0]  a0, a1;
    logic [31:0] e0, e1;
    logic        eb0, eb1;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tbl[2]  = '{2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22, 32'h22, 1'b0, 1'b0};
    tbl[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[4]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[6]  = '{2'b01, 5'd3, 5'd0, 32'h33, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3, 32'h33, 32'h33, 1'b1, 1'b1};
    tbl[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h33, 32'h33, 1'b1, 1'b1};
    tbl[8]  = '{2'b10, 5'd0, 5'd3, 32'h0, 32'h44, 1'b0, 5'd0, 5'd3, 5'd3, 32'h44, 32'h44, 1'b0, 1'b0};
    tbl[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 32'h44, 32'h0, 1'b0, 1'b0};
    tbl[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 1'b0, 1'b0};

    idle();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;

    // Clear sequence: not ready for 31 cycles, then every register reads zero.
    for (int i = 0; i < 31; i++) begin
      #3;
      chk("ready_during_clear", {31'd0, ready_b}, 32'd0);
      #0 tick();
    end
    #3;
    chk("ready_after_clear", {31'd0, ready_b}, 32'd1);
    for (int r = 1; r < 32; r += 2) begin
      rs_addr = {5'(r + 1 < 32 ? r + 1 : 1), 5'(r)};
      #3;
      chk("cleared_p0", val_b[31:0], 32'h0);
      chk("cleared_p1", val_b[63:32], 32'h0);
      #0 tick();
    end

    // Directed vectors: bypass, write conflict, x0, scoreboard.
    for (int i = 0; i < 11; i++) begin
      wr_valid    = tbl[i].wv;
      wr_rd       = {tbl[i].rd1, tbl[i].rd0};
      wr_value    = {tbl[i].v1, tbl[i].v0};
      alloc_valid = tbl[i].av;
      alloc_rd    = tbl[i].ard;
      rs_addr     = {tbl[i].a1, tbl[i].a0};
      #3;
      chk($sformatf("tbl%0d_val0", i), val_b[31:0], tbl[i].e0);
      chk($sformatf("tbl%0d_val1", i), val_b[63:32], tbl[i].e1);
      chk($sformatf("tbl%0d_busy0", i), {31'd0, busy_b[0]}, {31'd0, tbl[i].eb0});
      chk($sformatf("tbl%0d_busy1", i), {31'd0, busy_b[1]}, {31'd0, tbl[i].eb1});
      model_check();
      tick();
    end
    idle();

    // Fill the file, then reset mid-clear while writing: contents must end up zero.
    for (int r = 1; r < 32; r++) begin
      wr_valid = 2'b01; wr_rd = {5'd0, 5'(r)}; wr_value = {32'h0, $urandom | 32'h1};
      step();
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      wr_valid = 2'b11;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 31; i++) begin
      rand_inputs();
      wr_valid = 2'b11;
      #3;
      chk("ready_restart_clear", {31'd0, ready_b}, 32'd0);
      model_check();
      tick();
    end
    idle();
    #3;
    chk("ready_restart_done", {31'd0, ready_b}, 32'd1);
    #0 tick();
    for (int r = 1; r < 32; r++) begin
      rs_addr = {5'd0, 5'(r)};
      #3;
      chk($sformatf("restart_x%0d_zero", r), val_b[31:0], 32'h0);
      chk($sformatf("restart_x%0d_idle", r), {31'd0, busy_b[0]}, 32'd0);
      #0 tick();
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
